lrn_scheduler: RTL and testbench

- Sequences one LRN layer pass through the normalization datapath.
- Accepts paired square_sum/lrn_center vectors from the upstream reduction stage over a valid/ready handshake.
- Meters issue into the normalization block with a credit counter, because that block has depth-4 input FIFOs and no backpressure.
- Forwards normalized output vectors downstream and pulses done when the layer's last vector has returned.

---
 rtl/lrn_pkg.sv | 19 +
 rtl/lrn_scheduler_credit_counter.sv | 55 +++++
 rtl/lrn_scheduler.sv | 157 +++++++++++++++
 tb/tb_lrn_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lrn_pkg
// Brief    : State encoding and vector-width helper shared by the LRN scheduler.
// Revision : 1.0
// ============================================================================
package lrn_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    function automatic int vec_width(input int op_width, input int num_pe);
        return op_width * num_pe;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lrn_scheduler_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : credit_counter
// Brief    : Up/down credit counter with max clamp and overflow flag.
// Revision : 1.0
// ============================================================================
module credit_counter #(
    parameter int CREDITS = 4,
    parameter int WIDTH   = $clog2(CREDITS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_zero,
    output logic o_overflow
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(CREDITS);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;
    logic             w_full;

    assign w_full     = (r_count_q == c_MAX);
    assign o_zero     = (r_count_q == '0);
    // A return with no matching issue while full means a credit was never lent.
    assign o_overflow = i_inc & ~i_dec & w_full & ~i_load;

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = c_MAX;
        end else if (i_inc && !i_dec) begin
            if (!w_full) begin
                w_count_d = r_count_q + 1'b1;
            end
        end else if (i_dec && !i_inc) begin
            if (r_count_q != '0) begin
                w_count_d = r_count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count_q <= c_MAX;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lrn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lrn_scheduler
// Brief    : Sequences one LRN pass, credit-metering issue into normalization.
// Revision : 1.0
// ============================================================================
module lrn_scheduler
    import lrn_pkg::*;
#(
    parameter int OP_WIDTH  = 16,
    parameter int NUM_PE    = 4,
    parameter int CREDITS   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [CNT_WIDTH-1:0]                   cfg_num_vectors,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [vec_width(OP_WIDTH,NUM_PE)-1:0]  in_square_sum,
    input  logic [vec_width(OP_WIDTH,NUM_PE)-1:0]  in_lrn_center,
    output logic                                   norm_enable,
    output logic [vec_width(OP_WIDTH,NUM_PE)-1:0]  norm_square_sum,
    output logic [vec_width(OP_WIDTH,NUM_PE)-1:0]  norm_lrn_center,
    input  logic [vec_width(OP_WIDTH,NUM_PE)-1:0]  norm_out,
    input  logic                                   norm_out_valid,
    output logic [vec_width(OP_WIDTH,NUM_PE)-1:0]  out_data,
    output logic                                   out_valid,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err_credit
);

    localparam int VEC_W = vec_width(OP_WIDTH, NUM_PE);

    logic [1:0]           r_state_q,    w_state_d;
    logic [CNT_WIDTH-1:0] r_num_q,      w_num_d;
    logic [CNT_WIDTH-1:0] r_issued_q,   w_issued_d;
    logic [CNT_WIDTH-1:0] r_returned_q, w_returned_d;
    logic                 r_norm_en_q,  w_norm_en_d;
    logic [VEC_W-1:0]     r_norm_sq_q,  w_norm_sq_d;
    logic [VEC_W-1:0]     r_norm_ctr_q, w_norm_ctr_d;
    logic                 r_out_vld_q,  w_out_vld_d;
    logic [VEC_W-1:0]     r_out_data_q, w_out_data_d;
    logic                 r_done_q,     w_done_d;
    logic                 r_err_q,      w_err_d;

    logic w_active;
    logic w_issue;
    logic w_ret_count;
    logic w_start_go;
    logic w_cred_zero;
    logic w_cred_ovf;

    assign w_active    = (r_state_q == c_RUN) || (r_state_q == c_DRAIN);
    assign w_start_go  = start && (r_state_q == c_IDLE);
    assign in_ready    = (r_state_q == c_RUN) && !w_cred_zero && (r_issued_q != r_num_q);
    assign w_issue     = in_valid && in_ready;
    // Results outside a pass are forwarded but never counted against credits.
    assign w_ret_count = norm_out_valid && w_active;

    credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start_go),
        .i_inc      (w_ret_count),
        .i_dec      (w_issue),
        .o_zero     (w_cred_zero),
        .o_overflow (w_cred_ovf)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_num_d      = r_num_q;
        w_issued_d   = r_issued_q;
        w_returned_d = r_returned_q;
        case (r_state_q)
            c_IDLE: begin
                if (start) begin
                    w_num_d      = cfg_num_vectors;
                    w_issued_d   = '0;
                    w_returned_d = '0;
                    w_state_d    = (cfg_num_vectors == '0) ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                if (r_issued_q == r_num_q) begin
                    w_state_d = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (r_returned_q == r_num_q) begin
                    w_state_d = c_DONE;
                end
            end
            default: w_state_d = c_IDLE;
        endcase
        if (w_issue) begin
            w_issued_d = r_issued_q + 1'b1;
        end
        if (w_ret_count) begin
            w_returned_d = r_returned_q + 1'b1;
        end
    end

    always_comb begin
        w_norm_en_d  = w_issue;
        w_norm_sq_d  = w_issue ? in_square_sum : r_norm_sq_q;
        w_norm_ctr_d = w_issue ? in_lrn_center : r_norm_ctr_q;
        w_out_vld_d  = norm_out_valid;
        w_out_data_d = norm_out_valid ? norm_out : r_out_data_q;
        w_done_d     = (r_state_q == c_DONE);
        w_err_d      = r_err_q | (norm_out_valid & ~w_active) | w_cred_ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q    <= c_IDLE;
            r_num_q      <= '0;
            r_issued_q   <= '0;
            r_returned_q <= '0;
            r_norm_en_q  <= 1'b0;
            r_norm_sq_q  <= '0;
            r_norm_ctr_q <= '0;
            r_out_vld_q  <= 1'b0;
            r_out_data_q <= '0;
            r_done_q     <= 1'b0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_num_q      <= w_num_d;
            r_issued_q   <= w_issued_d;
            r_returned_q <= w_returned_d;
            r_norm_en_q  <= w_norm_en_d;
            r_norm_sq_q  <= w_norm_sq_d;
            r_norm_ctr_q <= w_norm_ctr_d;
            r_out_vld_q  <= w_out_vld_d;
            r_out_data_q <= w_out_data_d;
            r_done_q     <= w_done_d;
            r_err_q      <= w_err_d;
        end
    end

    assign norm_enable     = r_norm_en_q;
    assign norm_square_sum = r_norm_sq_q;
    assign norm_lrn_center = r_norm_ctr_q;
    assign out_valid       = r_out_vld_q;
    assign out_data        = r_out_data_q;
    assign done            = r_done_q;
    assign err_credit      = r_err_q;
    assign busy            = w_active;

endmodule
`default_nettype wire

// File: tb/tb_lrn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lrn_scheduler
// Brief    : Randomized self-checking bench with a queue-based pass model.
// Revision : 1.0
// ============================================================================
module tb_lrn_scheduler;
    import lrn_pkg::*;

    localparam int OPW = 16;
    localparam int PE  = 4;
    localparam int CR  = 4;
    localparam int CW  = 16;
    localparam int VW  = OPW * PE;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] cfg;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_sq, in_ctr;
    logic          norm_enable;
    logic [VW-1:0] norm_sq, norm_ctr, norm_out, out_data;
    logic          norm_out_valid;
    logic          out_valid, busy, done, err_credit;

    int n_cmp = 0;
    int n_err = 0;
    int st_done, st_max, st_coinc, st_done_cyc;
    bit st_bp;

    always #5 clk = ~clk;

    lrn_scheduler #(.OP_WIDTH(OPW), .NUM_PE(PE), .CREDITS(CR), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_num_vectors(cfg),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_square_sum(in_sq), .in_lrn_center(in_ctr),
        .norm_enable(norm_enable), .norm_square_sum(norm_sq), .norm_lrn_center(norm_ctr),
        .norm_out(norm_out), .norm_out_valid(norm_out_valid),
        .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done), .err_credit(err_credit)
    );

    // Stand-in for the normalization arithmetic; any injective mix will do.
    function automatic logic [VW-1:0] norm_model(input logic [VW-1:0] sq, input logic [VW-1:0] ctr);
        return sq ^ {ctr[VW/2-1:0], ctr[VW-1:VW/2]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_pass(input int n, input int lat, input int vprob, input bit tag);
        logic [VW-1:0] exp_sq[$], exp_ctr[$], exp_res[$], pipe_res[$];
        int pipe_due[$];
        int iss = 0, ret = 0, outs = 0, tagv = 1;
        bit pend_iss = 1'b0, pend_ret = 1'b0, nov;
        st_done = 0; st_max = 0; st_coinc = 0; st_done_cyc = -1; st_bp = 1'b0;
        @(negedge clk);
        start = 1'b1; cfg = CW'(n); in_valid = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            iss += int'(pend_iss);
            ret += int'(pend_ret);
            if (iss - ret > st_max) st_max = iss - ret;
            n_cmp++;
            if (dut.u_credit.r_count_q !== 3'(CR - (iss - ret))) begin
                n_err++;
                $display("FAIL credits n=%0d cyc=%0d: got %0d expected %0d", n, cyc, dut.u_credit.r_count_q, CR - (iss - ret));
            end
            n_cmp++;
            if (norm_enable !== pend_iss) begin
                n_err++;
                $display("FAIL norm_enable n=%0d cyc=%0d: got %b expected %b", n, cyc, norm_enable, pend_iss);
            end
            if (norm_enable === 1'b1) begin
                n_cmp++;
                if (exp_sq.size() == 0) begin
                    n_err++;
                    $display("FAIL norm_data n=%0d cyc=%0d: got issue expected none", n, cyc);
                end else begin
                    if (norm_sq !== exp_sq[0] || norm_ctr !== exp_ctr[0]) begin
                        n_err++;
                        $display("FAIL norm_data n=%0d cyc=%0d: got %h/%h expected %h/%h", n, cyc, norm_sq, norm_ctr, exp_sq[0], exp_ctr[0]);
                    end
                    void'(exp_sq.pop_front());
                    void'(exp_ctr.pop_front());
                end
                pipe_res.push_back(norm_model(norm_sq, norm_ctr));
                pipe_due.push_back(cyc + lat);
            end
            n_cmp++;
            if (out_valid !== pend_ret) begin
                n_err++;
                $display("FAIL out_valid n=%0d cyc=%0d: got %b expected %b", n, cyc, out_valid, pend_ret);
            end
            if (out_valid === 1'b1) begin
                outs++;
                n_cmp++;
                if (exp_res.size() == 0) begin
                    n_err++;
                    $display("FAIL out_data n=%0d cyc=%0d: got %h expected none", n, cyc, out_data);
                end else begin
                    if (out_data !== exp_res[0]) begin
                        n_err++;
                        $display("FAIL out_data n=%0d cyc=%0d: got %h expected %h", n, cyc, out_data, exp_res[0]);
                    end
                    void'(exp_res.pop_front());
                end
            end
            if (done === 1'b1) begin
                st_done++;
                if (st_done_cyc < 0) st_done_cyc = cyc;
            end
            n_cmp++;
            if (in_ready === 1'b1 && (iss >= n || iss - ret >= CR)) begin
                n_err++;
                $display("FAIL in_ready n=%0d cyc=%0d: got 1 expected 0 (issued %0d outstanding %0d)", n, cyc, iss, iss - ret);
            end
            nov = (pipe_due.size() != 0) && (pipe_due[0] == cyc);
            norm_out_valid = nov;
            if (nov) begin
                norm_out = pipe_res.pop_front();
                void'(pipe_due.pop_front());
            end
            in_valid = (st_done_cyc < 0) && ($urandom_range(99) < vprob);
            in_sq    = {$urandom, $urandom};
            in_ctr   = {$urandom, $urandom};
            if (tag) in_sq[OPW-1:0] = OPW'(tagv);
            pend_iss = in_valid && in_ready;
            if (pend_iss) begin
                exp_sq.push_back(in_sq);
                exp_ctr.push_back(in_ctr);
                exp_res.push_back(norm_model(in_sq, in_ctr));
                tagv++;
            end
            if (pend_iss && nov) st_coinc++;
            if (in_ready !== 1'b1 && iss < n && st_done_cyc < 0) st_bp = 1'b1;
            pend_ret = nov;
            if (st_done_cyc >= 0 && cyc >= st_done_cyc + 2) break;
        end
        in_valid = 1'b0;
        norm_out_valid = 1'b0;
        n_cmp++;
        if (st_done != 1) begin
            n_err++;
            $display("FAIL done_pulses n=%0d: got %0d expected 1", n, st_done);
        end
        n_cmp++;
        if (iss != n || outs != n) begin
            n_err++;
            $display("FAIL counts n=%0d: got issues %0d outputs %0d expected %0d", n, iss, outs, n);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after n=%0d: got %b expected 0", n, busy);
        end
        n_cmp++;
        if (err_credit !== 1'b0) begin
            n_err++;
            $display("FAIL err_credit n=%0d: got %b expected 0", n, err_credit);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if ({in_ready, norm_enable, out_valid, busy, done, err_credit} !== 6'b0 ||
            norm_sq !== '0 || norm_ctr !== '0 || out_data !== '0) begin
            n_err++;
            $display("FAIL %s: got ctl %b data %h/%h/%h expected all 0", tag,
                     {in_ready, norm_enable, out_valid, busy, done, err_credit}, norm_sq, norm_ctr, out_data);
        end
        n_cmp++;
        if (dut.r_state_q !== c_IDLE) begin
            n_err++;
            $display("FAIL %s_state: got %0d expected %0d", tag, dut.r_state_q, c_IDLE);
        end
    endtask

    task automatic test_reset();
        check_idle_outputs("reset_outputs");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        run_pass(1, 8, 100, 1'b0);
    endtask

    task automatic test_credit_limit();
        run_pass(10, 12, 100, 1'b0);
        n_cmp++;
        if (st_max != CR || st_bp != 1'b1) begin
            n_err++;
            $display("FAIL credit_limit: got max_outstanding %0d backpressure %b expected %0d 1", st_max, st_bp, CR);
        end
    endtask

    task automatic test_back_to_back();
        run_pass(6, 4, 100, 1'b1);
        n_cmp++;
        if (st_coinc == 0) begin
            n_err++;
            $display("FAIL coincident: got %0d coincident cycles expected >0", st_coinc);
        end
    endtask

    task automatic test_random();
        run_pass(int'($urandom_range(12, 5)), int'($urandom_range(10, 2)), 60, 1'b0);
    endtask

    task automatic test_zero();
        run_pass(0, 3, 100, 1'b0);
        n_cmp++;
        if (st_done_cyc != 2) begin
            n_err++;
            $display("FAIL zero_done_cycle: got %0d expected 2", st_done_cyc);
        end
    endtask

    task automatic test_spurious();
        logic [VW-1:0] v;
        v = {$urandom, $urandom};
        @(negedge clk);
        norm_out_valid = 1'b1;
        norm_out = v;
        @(negedge clk);
        norm_out_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== v || err_credit !== 1'b1) begin
            n_err++;
            $display("FAIL spurious: got vld %b data %h err %b expected 1 %h 1", out_valid, out_data, err_credit, v);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (err_credit !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_sticky: got err %b vld %b expected 1 0", err_credit, out_valid);
        end
        do_reset();
        n_cmp++;
        if (err_credit !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_clear: got %b expected 0", err_credit);
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        @(negedge clk);
        start = 1'b1; cfg = CW'(8); in_valid = 1'b0;
        for (int c = 0; c < 30 && acc < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = in_ready;
            if (in_ready === 1'b1) begin
                acc++;
                in_sq  = {$urandom, $urandom};
                in_ctr = {$urandom, $urandom};
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (acc != 3 || busy !== 1'b1 || norm_enable !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_setup: got issues %0d busy %b norm_en %b expected 3 1 1", acc, busy, norm_enable);
        end
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        norm_out_valid = 1'b1;
        norm_out = {$urandom, $urandom};
        @(negedge clk);
        norm_out_valid = 1'b0;
        n_cmp++;
        if (err_credit !== 1'b1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL late_return: got err %b vld %b expected 1 1", err_credit, out_valid);
        end
        do_reset();
        run_pass(2, 3, 100, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg = '0; in_valid = 1'b0;
        in_sq = '0; in_ctr = '0; norm_out = '0; norm_out_valid = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_credit_limit();
        test_back_to_back();
        test_random();
        test_zero();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
